// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller: walks DIGITS digits with a guard gap,
// double-buffers host updates to frame boundaries, and supports leading-zero blanking and blink.
module seven_seg_scan_ctrl #(
    parameter int DIGITS       = 4,
    parameter int DWELL_CYCLES = 50000,
    parameter int GUARD_CYCLES = 500,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  blank_lz,
    input  logic [DIGITS-1:0]     blink_mask,
    output logic [3:0]            dec_num,
    output logic [DIGITS-1:0]     dig_sel,
    output logic                  frame_tick,
    output logic                  load_ack
);

    localparam int MAXC = (DWELL_CYCLES > GUARD_CYCLES) ? DWELL_CYCLES : GUARD_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int IW   = $clog2(DIGITS);
    localparam int FW   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYCLES - 1);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
    localparam logic [FW-1:0] FR_LAST    = FW'(BLINK_FRAMES - 1);

    localparam logic [0:0] S_GUARD = 1'b0;
    localparam logic [0:0] S_DRIVE = 1'b1;

    logic [0:0]          state, nxt_state;
    logic [IW-1:0]       idx, nxt_idx;
    logic [CW-1:0]       cnt, nxt_cnt;
    logic [FW-1:0]       fcnt, nxt_fcnt;
    logic                phase, nxt_phase;
    logic [4*DIGITS-1:0] sh_val, nxt_sh_val, st_val;
    logic                sh_blz, nxt_sh_blz, st_blz;
    logic [DIGITS-1:0]   sh_mask, nxt_sh_mask, st_mask;
    logic                pending;
    logic                slot_end, boundary, run, sup;
    logic [DIGITS-1:0]   lz_sup, nxt_dig;

    // Outputs are registered from next-state values so they line up with the slot they describe.
    always_comb begin
        slot_end    = (state == S_GUARD) ? (cnt == GUARD_LAST) : (cnt == DWELL_LAST);
        boundary    = (state == S_DRIVE) && slot_end && (idx == IDX_LAST);
        nxt_state   = state;
        nxt_idx     = idx;
        nxt_cnt     = cnt + 1'b1;
        if (slot_end) begin
            nxt_cnt = '0;
            if (state == S_GUARD) begin
                nxt_state = S_DRIVE;
            end else begin
                nxt_state = S_GUARD;
                nxt_idx   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end
        end

        nxt_sh_val  = sh_val;
        nxt_sh_blz  = sh_blz;
        nxt_sh_mask = sh_mask;
        nxt_fcnt    = fcnt;
        nxt_phase   = phase;
        if (boundary) begin
            if (pending) begin
                nxt_sh_val  = st_val;
                nxt_sh_blz  = st_blz;
                nxt_sh_mask = st_mask;
            end
            if (fcnt == FR_LAST) begin
                nxt_fcnt  = '0;
                nxt_phase = ~phase;
            end else begin
                nxt_fcnt  = fcnt + 1'b1;
            end
        end

        // A digit is blank when it and every digit to its left hold zero.
        lz_sup = '0;
        run    = nxt_sh_blz;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            run       = run & (nxt_sh_val[4*i +: 4] == 4'd0);
            lz_sup[i] = run;
        end
        lz_sup[0] = 1'b0;

        sup     = lz_sup[nxt_idx] | (nxt_phase & nxt_sh_mask[nxt_idx]);
        nxt_dig = '1;
        if (nxt_state == S_DRIVE && !sup)
            nxt_dig[nxt_idx] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_GUARD;
            idx        <= '0;
            cnt        <= '0;
            fcnt       <= '0;
            phase      <= 1'b0;
            sh_val     <= '0;
            sh_blz     <= 1'b0;
            sh_mask    <= '0;
            st_val     <= '0;
            st_blz     <= 1'b0;
            st_mask    <= '0;
            pending    <= 1'b0;
            dec_num    <= 4'd0;
            dig_sel    <= '1;
            frame_tick <= 1'b0;
            load_ack   <= 1'b0;
        end else begin
            state      <= nxt_state;
            idx        <= nxt_idx;
            cnt        <= nxt_cnt;
            fcnt       <= nxt_fcnt;
            phase      <= nxt_phase;
            sh_val     <= nxt_sh_val;
            sh_blz     <= nxt_sh_blz;
            sh_mask    <= nxt_sh_mask;
            // A load on the boundary cycle lands in staging after the swap and waits a frame.
            if (load) begin
                st_val  <= value;
                st_blz  <= blank_lz;
                st_mask <= blink_mask;
                pending <= 1'b1;
            end else if (boundary) begin
                pending <= 1'b0;
            end
            dec_num    <= nxt_sh_val[4*nxt_idx +: 4];
            dig_sel    <= nxt_dig;
            frame_tick <= boundary;
            load_ack   <= boundary & pending;
        end
    end

endmodule
